// File: rtl/dls_pkg.sv
// Shared types for the delayed-lockstep checker.
package dls_pkg;

    typedef enum logic [1:0] {WARMUP, CHECK, SUSPECT, FAULT} dls_state_e;

    localparam int DLS_VGA_WIDTH = 43;

endpackage

// File: rtl/dls_delay_line.sv
// Primary-path delay line: DELAY-deep shift register, wire when DELAY==0.
module dls_delay_line #(
    parameter int WIDTH = 43,
    parameter int DELAY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [DELAY-1:0][WIDTH-1:0] sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/dls_lockstep_checker.sv
// Delayed-lockstep checker: delays primary, compares with redundant, filters, latches fault.
// Optional self-test inversion of RED_DATA[0] via macro DLS_FAULT_INJECT_EN.
module dls_lockstep_checker
    import dls_pkg::*;
#(
    parameter int WIDTH  = DLS_VGA_WIDTH,
    parameter int DELAY  = 2,
    parameter int THRESH = 1,
    parameter int CNT_W  = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             ENABLE,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] PRI_DATA,
    input  logic [WIDTH-1:0] RED_DATA,
`ifdef DLS_FAULT_INJECT_EN
    input  logic             INJECT_FAULT,
`endif
    output logic             MISMATCH,
    output logic             DLS_ERROR,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [WIDTH-1:0] SYNDROME
);

    localparam int RUN_W = $clog2(THRESH + 1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(THRESH - 1);
    localparam logic [2:0]       WARM_LAST = (DELAY == 0) ? 3'd0 : 3'(DELAY - 1);

    dls_state_e       state_q, state_n;
    logic [RUN_W-1:0] run_q, run_n;
    logic [2:0]       warm_q, warm_n;
    logic             mis_n, err_n;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] syn_n;
    logic [WIDTH-1:0] pri_d, red_c, diff;
    logic             miss, checking;

    dls_delay_line #(.WIDTH(WIDTH), .DELAY(DELAY)) u_dly (
        .clk  (HCLK),
        .rst_n(HRESETn),
        .din  (PRI_DATA),
        .dout (pri_d)
    );

`ifdef DLS_FAULT_INJECT_EN
    assign red_c = RED_DATA ^ {{(WIDTH-1){1'b0}}, INJECT_FAULT};
`else
    assign red_c = RED_DATA;
`endif

    assign diff     = pri_d ^ red_c;
    assign miss     = |diff;
    assign checking = (state_q != WARMUP);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= WARMUP;
            run_q     <= '0;
            warm_q    <= '0;
            MISMATCH  <= 1'b0;
            DLS_ERROR <= 1'b0;
            ERR_COUNT <= '0;
            SYNDROME  <= '0;
        end else begin
            state_q   <= state_n;
            run_q     <= run_n;
            warm_q    <= warm_n;
            MISMATCH  <= mis_n;
            DLS_ERROR <= err_n;
            ERR_COUNT <= cnt_n;
            SYNDROME  <= syn_n;
        end
    end

    always_comb begin
        state_n = state_q;
        run_n   = run_q;
        warm_n  = warm_q;
        mis_n   = checking & miss;
        err_n   = DLS_ERROR;
        cnt_n   = ERR_COUNT;
        syn_n   = SYNDROME;

        if (!ENABLE) begin
            state_n = WARMUP;
            run_n   = '0;
            warm_n  = '0;
            mis_n   = 1'b0;
        end else begin
            unique case (state_q)
                WARMUP: begin
                    if (DELAY == 0 || warm_q == WARM_LAST) state_n = CHECK;
                    else                                   warm_n  = warm_q + 3'd1;
                end
                CHECK: begin
                    if (miss) begin
                        run_n   = RUN_W'(1);
                        state_n = (THRESH == 1) ? FAULT : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (miss) begin
                        run_n = run_q + RUN_W'(1);
                        if (run_q == RUN_LAST) state_n = FAULT;
                    end else begin
                        run_n   = '0;
                        state_n = CHECK;
                    end
                end
                FAULT: ;
                default: state_n = WARMUP;
            endcase

            if (checking && miss) begin
                if (ERR_COUNT != {CNT_W{1'b1}}) cnt_n = ERR_COUNT + CNT_W'(1);
                // Keep the first-fault syndrome even if FAULT is re-entered after a re-warm.
                if (state_q != FAULT && state_n == FAULT) begin
                    err_n = 1'b1;
                    if (!DLS_ERROR) syn_n = diff;
                end
            end

            if (CLEAR && checking) state_n = CHECK;
        end

        // CLEAR overrides anything the same-cycle compare would have recorded.
        if (CLEAR) begin
            err_n = 1'b0;
            cnt_n = '0;
            syn_n = '0;
            run_n = '0;
        end
    end

endmodule

// File: tb/tb_dls_lockstep_checker.sv
// Randomised bench for dls_lockstep_checker: three configurations against a spec-level model.
module tb_dls_lockstep_checker;

    localparam int N = 3;
    localparam int DLY  [N] = '{2, 0, 1};
    localparam int TH   [N] = '{1, 1, 3};
    localparam int CMAX [N] = '{255, 255, 15};

    typedef struct {
        int          warm;
        bit          chk_on;
        bit          infault;
        int          run;
        bit          mis;
        bit          err;
        int          cnt;
        logic [42:0] syn;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, inj;
    logic [42:0] pri;
    logic [42:0] red   [N];
    logic [42:0] emask [N];
    logic [42:0] hist  [8];

    logic        mis [N];
    logic        err [N];
    logic [7:0]  cnt [N];
    logic [42:0] syn [N];
    logic [3:0]  cnt2;

    mdl_t m [N];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign cnt[2] = {4'b0, cnt2};

    dls_lockstep_checker #(.WIDTH(43), .DELAY(2), .THRESH(1), .CNT_W(8)) u0 (
        .HCLK(clk), .HRESETn(rst_n), .ENABLE(en), .CLEAR(clr),
        .PRI_DATA(pri), .RED_DATA(red[0]),
`ifdef DLS_FAULT_INJECT_EN
        .INJECT_FAULT(inj),
`endif
        .MISMATCH(mis[0]), .DLS_ERROR(err[0]), .ERR_COUNT(cnt[0]), .SYNDROME(syn[0]));

    dls_lockstep_checker #(.WIDTH(43), .DELAY(0), .THRESH(1), .CNT_W(8)) u1 (
        .HCLK(clk), .HRESETn(rst_n), .ENABLE(en), .CLEAR(clr),
        .PRI_DATA(pri), .RED_DATA(red[1]),
`ifdef DLS_FAULT_INJECT_EN
        .INJECT_FAULT(inj),
`endif
        .MISMATCH(mis[1]), .DLS_ERROR(err[1]), .ERR_COUNT(cnt[1]), .SYNDROME(syn[1]));

    dls_lockstep_checker #(.WIDTH(43), .DELAY(1), .THRESH(3), .CNT_W(4)) u2 (
        .HCLK(clk), .HRESETn(rst_n), .ENABLE(en), .CLEAR(clr),
        .PRI_DATA(pri), .RED_DATA(red[2]),
`ifdef DLS_FAULT_INJECT_EN
        .INJECT_FAULT(inj),
`endif
        .MISMATCH(mis[2]), .DLS_ERROR(err[2]), .ERR_COUNT(cnt2), .SYNDROME(syn[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Primary value the instance should see this cycle: PRI from DLY cycles ago (zeros after reset).
    function automatic logic [42:0] pdel(int i);
        int k;
        k = DLY[i] - 1;
        if (DLY[i] == 0) return pri;
        return hist[k];
    endfunction

    function automatic mdl_t step(mdl_t mi, int i, logic pen, logic pclr,
                                  logic [42:0] pd, logic [42:0] rc);
        mdl_t n;
        logic miss;
        n    = mi;
        miss = (pd != rc);
        if (!pen) begin
            n.warm = 0; n.chk_on = 0; n.infault = 0; n.run = 0; n.mis = 0;
        end else begin
            n.mis = mi.chk_on && miss;
            if (!mi.chk_on) begin
                if (mi.warm + 1 >= DLY[i]) n.chk_on = 1;
                else                       n.warm = mi.warm + 1;
            end else if (pclr) begin
                n.infault = 0;
            end else if (miss) begin
                n.cnt = (mi.cnt < CMAX[i]) ? mi.cnt + 1 : mi.cnt;
                if (!mi.infault) begin
                    n.run = mi.run + 1;
                    if (n.run >= TH[i]) begin
                        n.infault = 1;
                        n.err     = 1;
                        if (!mi.err) n.syn = pd ^ rc;
                    end
                end
            end else if (!mi.infault) begin
                n.run = 0;
            end
        end
        if (pclr) begin
            n.err = 0; n.cnt = 0; n.syn = '0; n.run = 0;
        end
        return n;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0, 43'h0};
        for (int k = 0; k < 8; k++) hist[k] = '0;
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.mismatch", i), 64'(mis[i]), 64'(m[i].mis));
            chk($sformatf("u%0d.dls_error", i), 64'(err[i]), 64'(m[i].err));
            chk($sformatf("u%0d.err_count", i), 64'(cnt[i]), 64'(m[i].cnt));
            chk($sformatf("u%0d.syndrome", i), 64'(syn[i]), 64'(m[i].syn));
        end
    endtask

    // Apply new primary data and build each redundant stream from the delayed primary plus its error mask.
    task automatic drive(input logic [42:0] p);
        pri = p;
        for (int i = 0; i < N; i++) red[i] = pdel(i) ^ emask[i];
    endtask

    task automatic tick();
        logic [42:0] rc;
        for (int i = 0; i < N; i++) begin
            rc = red[i];
`ifdef DLS_FAULT_INJECT_EN
            if (inj) rc[0] = ~rc[0];
`endif
            m[i] = step(m[i], i, en, clr, pdel(i), rc);
        end
        @(posedge clk);
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pri;
        #1;
        compare_all();
    endtask

    function automatic logic [42:0] rnd43();
        return 43'({$urandom(), $urandom()});
    endfunction

    task automatic set_masks(input logic [42:0] a, input logic [42:0] b, input logic [42:0] c);
        emask[0] = a; emask[1] = b; emask[2] = c;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; inj = 1'b0;
        set_masks('0, '0, '0);
        mdl_reset();
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Matched streams under random data: never a mismatch.
        en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            drive(rnd43());
            tick();
        end
        chk("t1.u0_count", 64'(cnt[0]), 64'd0);
        chk("t1.u0_error", 64'(err[0]), 64'd0);

        // Single-bit miss on same-cycle lockstep instance.
        set_masks('0, 43'h1, '0);
        drive(rnd43()); tick();
        set_masks('0, '0, '0);
        chk("t2.mismatch", 64'(mis[1]), 64'd1);
        chk("t2.error", 64'(err[1]), 64'd1);
        chk("t2.syndrome", 64'(syn[1]), 64'h1);
        chk("t2.count", 64'(cnt[1]), 64'd1);

        // CLEAR coincident with a miss while faulted.
        clr = 1'b1;
        set_masks('0, 43'h5, '0);
        drive(rnd43()); tick();
        clr = 1'b0;
        chk("t4.error", 64'(err[1]), 64'd0);
        chk("t4.count", 64'(cnt[1]), 64'd0);
        chk("t4.syndrome", 64'(syn[1]), 64'd0);
        set_masks('0, 43'h2, '0);
        drive(rnd43()); tick();
        chk("t4.recheck_error", 64'(err[1]), 64'd1);
        chk("t4.recheck_syn", 64'(syn[1]), 64'h2);
        set_masks('0, '0, '0);
        clr = 1'b1; drive(rnd43()); tick(); clr = 1'b0;

        // THRESH=3 filter: two misses absorbed, then three in a row fault.
        for (int c = 0; c < 2; c++) begin
            set_masks('0, '0, 43'h100 << c);
            drive(rnd43()); tick();
        end
        set_masks('0, '0, '0);
        drive(rnd43()); tick();
        chk("t3.filtered_error", 64'(err[2]), 64'd0);
        chk("t3.filtered_count", 64'(cnt[2]), 64'd2);
        for (int c = 0; c < 3; c++) begin
            set_masks('0, '0, 43'h40 | 43'(c));
            drive(rnd43()); tick();
            if (c == 1) chk("t3.second_error", 64'(err[2]), 64'd0);
        end
        chk("t3.fault_error", 64'(err[2]), 64'd1);
        chk("t3.fault_count", 64'(cnt[2]), 64'd5);
        chk("t3.fault_syn", 64'(syn[2]), 64'h42);

        // Saturation of the 4-bit counter, then asynchronous reset mid-cycle.
        set_masks('0, '0, 43'h7);
        for (int c = 0; c < 20; c++) begin
            drive(rnd43()); tick();
        end
        chk("t5.saturated", 64'(cnt[2]), 64'd15);
        #2 rst_n = 1'b0;
        #1;
        mdl_reset();
        chk("t5.async_count", 64'(cnt[2]), 64'd0);
        chk("t5.async_error", 64'(err[2]), 64'd0);
        chk("t5.async_syn", 64'(syn[2]), 64'd0);
        compare_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ENABLE low right after reset, then one enabled warm-up edge with no compare.
        en = 1'b0;
        set_masks('0, '0, 43'h1);
        drive(rnd43()); tick();
        chk("t6.disabled_mis", 64'(mis[2]), 64'd0);
        en = 1'b1;
        drive(rnd43()); tick();
        chk("t6.warm_mis", 64'(mis[2]), 64'd0);
        chk("t6.warm_count", 64'(cnt[2]), 64'd0);
        set_masks('0, '0, '0);
        repeat (3) begin drive(rnd43()); tick(); end
`ifdef DLS_FAULT_INJECT_EN
        inj = 1'b1;
        drive(rnd43()); tick();
        inj = 1'b0;
        chk("t6.inject_error", 64'(err[0]), 64'd1);
        chk("t6.inject_syn", 64'(syn[0]), 64'h1);
        clr = 1'b1; drive(rnd43()); tick(); clr = 1'b0;
`endif

        // Mixed random traffic: sparse misses, enable drops and clears.
        for (int c = 0; c < 400; c++) begin
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 29) == 0);
`ifdef DLS_FAULT_INJECT_EN
            inj = ($urandom_range(0, 24) == 0);
`endif
            for (int i = 0; i < N; i++)
                emask[i] = ($urandom_range(0, 7) == 0) ? 43'(64'd1 << $urandom_range(0, 42)) : '0;
            drive(rnd43());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
